// File: rtl/lc3_decode_pkg.sv
// Shared types and encodings for the LC3 decode stage.
//   opcode_t     : 4-bit LC3 opcode (IR[15:12])
//   e_control_t  : 6-bit execute control word {alu, pcselect1, pcselect2, op2select}
//   *_ALU/PC1/PC2/OP2/WB constants : field encodings used by the decoder
package lc3_decode_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ECTRL_W  = 6;
  localparam int unsigned WCTRL_W  = 2;
  localparam int unsigned ALU_W    = 2;
  localparam int unsigned PC1_W    = 2;

  typedef enum logic [OPCODE_W-1:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  // ALU operation select
  localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_W-1:0] ALU_AND = 2'b01;
  localparam logic [ALU_W-1:0] ALU_NOT = 2'b10;

  // Address adder operand 1: sign-extended offset field or zero
  localparam logic [PC1_W-1:0] PC1_OFF11 = 2'b00;
  localparam logic [PC1_W-1:0] PC1_OFF9  = 2'b01;
  localparam logic [PC1_W-1:0] PC1_OFF6  = 2'b10;
  localparam logic [PC1_W-1:0] PC1_ZERO  = 2'b11;

  // Address adder operand 2: next PC or base register
  localparam logic PC2_NPC  = 1'b1;
  localparam logic PC2_VSR1 = 1'b0;

  // ALU second operand: register or imm5
  localparam logic OP2_VSR2 = 1'b1;
  localparam logic OP2_IMM5 = 1'b0;

  // Writeback source select
  localparam logic [WCTRL_W-1:0] WB_ALU   = 2'b00;
  localparam logic [WCTRL_W-1:0] WB_MEM   = 2'b01;
  localparam logic [WCTRL_W-1:0] WB_PCREL = 2'b10;

  typedef struct packed {
    logic [ALU_W-1:0] alu_control;
    logic [PC1_W-1:0] pcselect1;
    logic             pcselect2;
    logic             op2select;
  } e_control_t;

  // Assemble an execute control word from its fields.
  function automatic e_control_t mk_e(input logic [ALU_W-1:0] alu,
                                      input logic [PC1_W-1:0] pc1,
                                      input logic             pc2,
                                      input logic             op2);
    e_control_t e;
    e.alu_control = alu;
    e.pcselect1   = pc1;
    e.pcselect2   = pc2;
    e.op2select   = op2;
    return e;
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder for the LC3 decode stage.
//   opcode_i    : instruction opcode (IR[15:12])
//   imm_sel_i   : IR[5], selects imm5 vs. register form for ADD/AND
//   e_ctrl_c_o  : execute control word
//   w_ctrl_c_o  : writeback source select
//   mem_ctrl_c_o: indirect memory access (LDI/STI)
//   illegal_c_o : opcode not supported by this core
module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  opcode_t                  opcode_i,
  input  logic                     imm_sel_i,
  output e_control_t               e_ctrl_c_o,
  output logic [WCTRL_W-1:0]       w_ctrl_c_o,
  output logic                     mem_ctrl_c_o,
  output logic                     illegal_c_o
);

  logic op2_sel;

  // IR[5]=1 means immediate form, so the ALU takes imm5 instead of VSR2.
  assign op2_sel = imm_sel_i ? OP2_IMM5 : OP2_VSR2;

  // Opcode -> control words; unsupported opcodes leave every word at zero.
  always_comb begin
    e_ctrl_c_o   = mk_e(ALU_ADD, PC1_OFF11, PC2_VSR1, OP2_IMM5);
    w_ctrl_c_o   = WB_ALU;
    mem_ctrl_c_o = 1'b0;
    illegal_c_o  = 1'b0;
    case (opcode_i)
      OP_ADD: e_ctrl_c_o = mk_e(ALU_ADD, PC1_OFF11, PC2_VSR1, op2_sel);
      OP_AND: e_ctrl_c_o = mk_e(ALU_AND, PC1_OFF11, PC2_VSR1, op2_sel);
      OP_NOT: e_ctrl_c_o = mk_e(ALU_NOT, PC1_OFF11, PC2_VSR1, OP2_IMM5);
      OP_BR,
      OP_ST:  e_ctrl_c_o = mk_e(ALU_ADD, PC1_OFF9, PC2_NPC, OP2_IMM5);
      OP_LD: begin
        e_ctrl_c_o = mk_e(ALU_ADD, PC1_OFF9, PC2_NPC, OP2_IMM5);
        w_ctrl_c_o = WB_MEM;
      end
      OP_LDI: begin
        e_ctrl_c_o   = mk_e(ALU_ADD, PC1_OFF9, PC2_NPC, OP2_IMM5);
        w_ctrl_c_o   = WB_MEM;
        mem_ctrl_c_o = 1'b1;
      end
      OP_STI: begin
        e_ctrl_c_o   = mk_e(ALU_ADD, PC1_OFF9, PC2_NPC, OP2_IMM5);
        mem_ctrl_c_o = 1'b1;
      end
      OP_LEA: begin
        e_ctrl_c_o = mk_e(ALU_ADD, PC1_OFF9, PC2_NPC, OP2_IMM5);
        w_ctrl_c_o = WB_PCREL;
      end
      OP_LDR: begin
        e_ctrl_c_o = mk_e(ALU_ADD, PC1_OFF6, PC2_VSR1, OP2_IMM5);
        w_ctrl_c_o = WB_MEM;
      end
      OP_STR: e_ctrl_c_o = mk_e(ALU_ADD, PC1_OFF6, PC2_VSR1, OP2_IMM5);
      OP_JMP: e_ctrl_c_o = mk_e(ALU_ADD, PC1_ZERO, PC2_VSR1, OP2_IMM5);
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// LC3 pipeline decode stage: captures the fetched instruction, next PC and
// condition codes when enabled and registers the downstream control words.
//   clock, reset      : rising-edge clock, async active-high reset
//   enable_decode     : capture/decode enable
//   instr_dout        : instruction word from instruction memory
//   npc_in, psr       : PC+1 from fetch, current NZP codes
//   IR, npc_out, psr_out            : registered instruction/PC/NZP
//   E_Control, W_Control, Mem_Control: registered stage controls
//   decode_valid      : registered enable_decode
//   illegal_op        : last captured opcode is unsupported
module lc3_decode
  import lc3_decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PSR_W   = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_decode,
  input  logic [INSTR_W-1:0]  instr_dout,
  input  logic [INSTR_W-1:0]  npc_in,
  input  logic [PSR_W-1:0]    psr,
  output logic [INSTR_W-1:0]  IR,
  output logic [INSTR_W-1:0]  npc_out,
  output logic [PSR_W-1:0]    psr_out,
  output logic [ECTRL_W-1:0]  E_Control,
  output logic [WCTRL_W-1:0]  W_Control,
  output logic                Mem_Control,
  output logic                decode_valid,
  output logic                illegal_op
);

  opcode_t              opcode;
  e_control_t           e_ctrl;
  logic [WCTRL_W-1:0]   w_ctrl;
  logic                 mem_ctrl;
  logic                 illegal;

  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [INSTR_W-1:0]   npc_q, npc_d;
  logic [PSR_W-1:0]     psr_q, psr_d;
  e_control_t           e_q, e_d;
  logic [WCTRL_W-1:0]   w_q, w_d;
  logic                 mem_q, mem_d;
  logic                 valid_q, valid_d;
  logic                 illegal_q, illegal_d;

  assign opcode = opcode_t'(instr_dout[INSTR_W-1 -: OPCODE_W]);

  lc3_decode_ctrl u_ctrl (
    .opcode_i     (opcode),
    .imm_sel_i    (instr_dout[5]),
    .e_ctrl_c_o   (e_ctrl),
    .w_ctrl_c_o   (w_ctrl),
    .mem_ctrl_c_o (mem_ctrl),
    .illegal_c_o  (illegal)
  );

  // Capture on enable, otherwise hold; valid simply tracks the enable.
  always_comb begin
    ir_d      = ir_q;
    npc_d     = npc_q;
    psr_d     = psr_q;
    e_d       = e_q;
    w_d       = w_q;
    mem_d     = mem_q;
    illegal_d = illegal_q;
    valid_d   = enable_decode;
    if (enable_decode) begin
      ir_d      = instr_dout;
      npc_d     = npc_in;
      psr_d     = psr;
      e_d       = e_ctrl;
      w_d       = w_ctrl;
      mem_d     = mem_ctrl;
      illegal_d = illegal;
    end
  end

  // Stage registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q      <= '0;
      npc_q     <= '0;
      psr_q     <= '0;
      e_q       <= '0;
      w_q       <= '0;
      mem_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      psr_q     <= psr_d;
      e_q       <= e_d;
      w_q       <= w_d;
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign psr_out      = psr_q;
  assign E_Control    = e_q;
  assign W_Control    = w_q;
  assign Mem_Control  = mem_q;
  assign decode_valid = valid_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: each driven cycle pushes the expected
// output set, a monitor pops and compares it one clock later.
module tb_lc3_decode;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [2:0]  psr;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [2:0]  psr_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  lc3_decode #(.INSTR_W(16), .PSR_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .instr_dout   (instr_dout),
    .npc_in       (npc_in),
    .psr          (psr),
    .IR           (IR),
    .npc_out      (npc_out),
    .psr_out      (psr_out),
    .E_Control    (E_Control),
    .W_Control    (W_Control),
    .Mem_Control  (Mem_Control),
    .decode_valid (decode_valid),
    .illegal_op   (illegal_op)
  );

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [2:0]  psr;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        v;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   checks   = 0;
  int   failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_outs(input string tag, input exp_t e);
    check_eq({tag, ".IR"},          32'(IR),           32'(e.ir));
    check_eq({tag, ".npc_out"},     32'(npc_out),      32'(e.npc));
    check_eq({tag, ".psr_out"},     32'(psr_out),      32'(e.psr));
    check_eq({tag, ".E_Control"},   32'(E_Control),    32'(e.e));
    check_eq({tag, ".W_Control"},   32'(W_Control),    32'(e.w));
    check_eq({tag, ".Mem_Control"}, 32'(Mem_Control),  32'(e.m));
    check_eq({tag, ".decode_valid"},32'(decode_valid), 32'(e.v));
    check_eq({tag, ".illegal_op"},  32'(illegal_op),   32'(e.ill));
  endtask

  // Reference decode table: {E[5:0], W[1:0], M, illegal}.
  function automatic logic [9:0] ref_decode(input logic [15:0] ir);
    logic [5:0] e;
    logic [1:0] w;
    logic       m;
    logic       ill;
    e = 6'h00; w = 2'b00; m = 1'b0; ill = 1'b0;
    case (ir[15:12])
      4'h1: e = {5'b00000, ~ir[5]};
      4'h5: e = {5'b01000, ~ir[5]};
      4'h9: e = 6'h20;
      4'h0, 4'h3: e = 6'h06;
      4'h2: begin e = 6'h06; w = 2'b01; end
      4'hA: begin e = 6'h06; w = 2'b01; m = 1'b1; end
      4'hB: begin e = 6'h06; m = 1'b1; end
      4'hE: begin e = 6'h06; w = 2'b10; end
      4'h6: begin e = 6'h08; w = 2'b01; end
      4'h7: e = 6'h08;
      4'hC: e = 6'h0C;
      default: ill = 1'b1;
    endcase
    return {e, w, m, ill};
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue its expected result.
  task automatic step(input logic en, input logic [15:0] ins, input logic [15:0] npc,
                      input logic [2:0] p);
    logic [9:0] d;
    @(negedge clock);
    enable_decode = en;
    instr_dout    = ins;
    npc_in        = npc;
    psr           = p;
    model.v = en;
    if (en) begin
      d         = ref_decode(ins);
      model.ir  = ins;
      model.npc = npc;
      model.psr = p;
      model.e   = d[9:4];
      model.w   = d[3:2];
      model.m   = d[1];
      model.ill = d[0];
    end
    exp_q.push_back(model);
  endtask

  // Monitor: one clock after each driven cycle, compare against the queued entry.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) compare_outs("sb", exp_q.pop_front());
  end

  initial begin
    logic [15:0] ins;
    reset         = 1'b1;
    enable_decode = 1'b1;
    instr_dout    = 16'h12A3;
    npc_in        = 16'h3001;
    psr           = 3'b010;
    model         = '0;

    // Outputs stay zero through a clock edge while reset is held with enable high.
    #1 compare_outs("reset", '0);
    @(posedge clock); #1;
    compare_outs("reset_edge", '0);
    @(negedge clock);
    reset         = 1'b0;
    enable_decode = 1'b0;

    // Directed sequence.
    step(1'b1, 16'h12A3, 16'h3001, 3'b010);   // ADD imm
    step(1'b1, 16'h5705, 16'h3002, 3'b100);   // AND reg
    step(1'b1, 16'hA005, 16'h3003, 3'b001);   // LDI, back-to-back
    step(1'b1, 16'h6284, 16'h3004, 3'b010);   // LDR
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 16'h0000, 3'b000);
    step(1'b1, 16'hF025, 16'h3005, 3'b100);   // TRAP
    step(1'b1, 16'hC1C0, 16'h3006, 3'b001);   // JMP clears illegal
    step(1'b1, 16'h1042, 16'h3007, 3'b010);   // ADD reg
    step(1'b1, 16'h507F, 16'h3008, 3'b010);   // AND imm
    step(1'b1, 16'h923F, 16'h3009, 3'b100);   // NOT

    // Every opcode with random operand fields and occasional stalls.
    for (int op = 0; op < 16; op++) begin
      ins = {4'(op), 12'($urandom)};
      step(1'b1, ins, 16'($urandom), 3'($urandom));
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 3'($urandom));
    end

    // Mid-cycle asynchronous reset after a LEA capture.
    step(1'b1, 16'hE3FF, 16'h4000, 3'b001);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 compare_outs("async_reset", '0);
    model = '0;
    @(negedge clock);
    enable_decode = 1'b0;
    reset         = 1'b0;
    step(1'b0, 16'h1234, 16'h5678, 3'b111);
    step(1'b0, 16'hE3FF, 16'h4000, 3'b001);
    step(1'b1, 16'h2A10, 16'h4001, 3'b100);   // LD after recovery

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clock);
    #2;
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
